// File: rtl/key_load_sched_if.sv
// key_load_sched_if: request/stream/converter/delivery bundle between requesters, converter and scheduler
// master: requesters plus converter drive req, s_data, s_valid, conv_ready, conv_key, key_ack
// slave:  the scheduler drives s_ready, grant, conv_*, key_out/valid/owner, busy, err
interface key_load_sched_if #(
  parameter int DATA_WIDTH = 32,
  parameter int KEY_WIDTH = 128
);
  logic [1:0] req;
  logic [2*DATA_WIDTH-1:0] s_data;
  logic [1:0] s_valid;
  logic [1:0] s_ready;
  logic [1:0] grant;
  logic [DATA_WIDTH-1:0] conv_data;
  logic conv_valid;
  logic conv_rst;
  logic conv_ready;
  logic [KEY_WIDTH-1:0] conv_key;
  logic [KEY_WIDTH-1:0] key_out;
  logic key_valid;
  logic key_owner;
  logic key_ack;
  logic busy;
  logic err;
  modport master (
    output req, s_data, s_valid, conv_ready, conv_key, key_ack,
    input s_ready, grant, conv_data, conv_valid, conv_rst, key_out, key_valid, key_owner, busy, err
  );
  modport slave (
    input req, s_data, s_valid, conv_ready, conv_key, key_ack,
    output s_ready, grant, conv_data, conv_valid, conv_rst, key_out, key_valid, key_owner, busy, err
  );
endinterface

// File: rtl/key_load_sched.sv
// key_load_sched: round-robin two-requester key loader streaming words to a width converter and delivering the key
// clk/reset: rising-edge clock, synchronous active-high reset
// bus (slave): requests and word streams in, converter stream out, assembled key delivery out, busy/err status
module key_load_sched #(
  parameter int DATA_WIDTH = 32,
  parameter int KEY_WIDTH = 128,
  parameter int TIMEOUT = 64
) (
  input logic clk,
  input logic reset,
  key_load_sched_if.slave bus
);
  localparam int WORDS = KEY_WIDTH / DATA_WIDTH;
  localparam int CW = $clog2(WORDS + 1);
  localparam int SW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, STREAM, WAIT_CONV, PRESENT} state_t;
  state_t state, state_n;
  logic [CW-1:0] wcnt;
  logic [SW-1:0] stall;
  logic last;
  logic g, win, start, take, done, load, ack, stalled, abort;
  logic [DATA_WIDTH-1:0] word;
  // last holds the index of the requester served most recently; a tie goes to the other one
  always_comb begin
    g = bus.grant[1];
    win = (bus.req == 2'b11) ? ~last : bus.req[1];
    start = state == IDLE && |bus.req;
    take = state == STREAM && bus.s_valid[g] && bus.s_ready[g];
    done = take && wcnt == CW'(WORDS - 1);
    load = state == WAIT_CONV && bus.conv_ready;
    ack = state == PRESENT && bus.key_ack;
    stalled = (state == STREAM && !take) || (state == WAIT_CONV && !bus.conv_ready);
    abort = stalled && stall == SW'(TIMEOUT - 1);
    word = g ? bus.s_data[2*DATA_WIDTH-1:DATA_WIDTH] : bus.s_data[DATA_WIDTH-1:0];
    state_n = abort ? IDLE : start ? STREAM : done ? WAIT_CONV : load ? PRESENT : ack ? IDLE : state;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      wcnt <= '0;
      stall <= '0;
      last <= 1'b1;
      bus.grant <= '0;
      bus.s_ready <= '0;
      bus.conv_data <= '0;
      bus.conv_valid <= 1'b0;
      bus.conv_rst <= 1'b1;
      bus.key_out <= '0;
      bus.key_valid <= 1'b0;
      bus.key_owner <= 1'b0;
      bus.busy <= 1'b0;
      bus.err <= 1'b0;
    end else begin
      state <= state_n;
      wcnt <= (done || abort) ? '0 : take ? wcnt + CW'(1) : wcnt;
      stall <= (take || state_n != state) ? '0 : stalled ? stall + SW'(1) : stall;
      last <= ack ? g : last;
      bus.grant <= start ? {win, ~win} : (abort || ack) ? 2'b00 : bus.grant;
      bus.s_ready <= start ? {win, ~win} : (done || abort) ? 2'b00 : bus.s_ready;
      bus.conv_data <= take ? word : bus.conv_data;
      bus.conv_valid <= take;
      bus.conv_rst <= abort;
      bus.key_out <= load ? bus.conv_key : bus.key_out;
      bus.key_valid <= load | (bus.key_valid & ~(ack | abort));
      bus.key_owner <= load ? g : bus.key_owner;
      bus.busy <= state_n != IDLE;
      bus.err <= abort;
    end
  end
endmodule

// File: doc/key_load_sched.md
KEY_LOAD_SCHED -- requirements
Module: key_load_sched

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: width of one key stream word.
REQ-002 SHALL have parameter KEY_WIDTH, default 128: width of an assembled key; WORDS = KEY_WIDTH/DATA_WIDTH, default 4.
REQ-003 SHALL have parameter TIMEOUT, default 64: stall cycles tolerated before abort.
REQ-004 SHALL use one clock; reset is synchronous and active-high: `clk  in  1`, the rising-edge clock.
REQ-005 SHALL have `reset  in  1`: synchronous, active-high; the only reset.
REQ-006 SHALL have `req  in  2`: per-requester key-load request, one bit per requester.
REQ-007 SHALL have `s_data  in  2*DATA_WIDTH`: requester i word in bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 SHALL have `s_valid  in  2`, the per-requester word valid, and `s_ready  out  2`, the per-requester word accept.
REQ-009 SHALL have `grant  out  2`: one-hot current owner; 0 when idle.
REQ-010 SHALL have `conv_data  out  DATA_WIDTH` and `conv_valid  out  1`: word stream into the width converter.
REQ-011 SHALL have `conv_rst  out  1`: one-cycle pulse that clears converter partial state.
REQ-012 SHALL have `conv_ready  in  1`, the converter's "key assembled" flag, and `conv_key  in  KEY_WIDTH`, the assembled key.
REQ-013 SHALL have `key_out  out  KEY_WIDTH`, `key_valid  out  1`, `key_owner  out  1` and `key_ack  in  1`: delivery of the assembled key to its owner.
REQ-014 SHALL have `busy  out  1`, high when the state is not IDLE, and `err  out  1`, a one-cycle timeout pulse.

Function
REQ-015 SHALL implement FSM states IDLE, STREAM, WAIT_CONV and PRESENT; all outputs SHALL be registered.
REQ-016 In IDLE with any req bit high, the FSM SHALL grant one requester next cycle and enter STREAM.
- Arbitration is round-robin.
- If both req bits are high, the requester not served last SHALL win.
REQ-017 req SHALL be sampled only in IDLE; a req deassertion after grant SHALL have no effect.
REQ-018 In STREAM, s_ready[g] SHALL be high for the granted requester only, while word count < WORDS; s_ready SHALL be low for the other requester.
REQ-019 Each s_valid[g]&s_ready[g] cycle SHALL place that word on conv_data with conv_valid=1 in the following cycle.
- conv_valid SHALL be low otherwise.
- One word per cycle maximum; WORDS back-to-back words take WORDS cycles.
REQ-020 After the WORDS-th accepted word, s_ready SHALL drop in the same cycle, the word count SHALL clear and the FSM SHALL enter WAIT_CONV.
REQ-021 In WAIT_CONV, the first cycle with conv_ready=1 SHALL load conv_key into key_out and enter PRESENT.
REQ-022 In PRESENT, key_valid=1 and key_owner=g SHALL hold, with key_out stable, until key_ack=1.
- That cycle SHALL return to IDLE with grant=0 and update the last-served pointer to g.
- key_ack outside PRESENT SHALL be ignored.
REQ-023 A stall counter SHALL count cycles in STREAM with no accepted word, and cycles in WAIT_CONV; it SHALL clear on every accepted word and on every state change.
REQ-024 When the stall counter reaches TIMEOUT, the block SHALL in one cycle:
- pulse err and conv_rst;
- clear grant, word count and key_valid;
- return to IDLE without updating the last-served pointer.
REQ-025 PRESENT SHALL have no timeout.
REQ-026 The word counter SHALL be ceil(log2(WORDS+1)) bits and SHALL never wrap past WORDS.

Reset
REQ-027 While reset=1 at a clock edge, the state SHALL go to IDLE and the following SHALL clear on the next edge:
- grant=0, s_ready=0, conv_valid=0, conv_data=0;
- key_out=0, key_valid=0, key_owner=0;
- busy=0, err=0, counters=0;
- last-served pointer = requester 1, so requester 0 wins the first tie.
REQ-028 reset SHALL also drive conv_rst=1 for each cycle it is asserted; reset mid-transaction SHALL discard all partial state.

Verification
REQ-029 Single load: req=01, s_data0 words BBBBBBBB,0,0,0 back-to-back; converter returns conv_ready with key 0x000000000000000000000000BBBBBBBB (BBBBBBBB in the low word) -> grant=01 at cycle+1, conv_valid high for 4 consecutive cycles, key_valid=1, key_owner=0, key_out equals conv_key.
REQ-030 Tie and fairness: req=11 held across three transactions -> grants 01, 10, 01; s_ready never high for both requesters.
REQ-031 Gapped stream: s_valid toggles 1,0,1,0,... -> exactly 4 conv_valid pulses, no err, conv_data matches the accepted words in order.
REQ-032 Timeout: 2 words then s_valid=0 for 64 cycles -> err and conv_rst pulse once, grant=00, busy=0; the next req=10 is granted normally.
REQ-033 Held delivery: key_ack withheld 20 cycles -> key_valid and key_out stable for 20 cycles, no err; ack returns the FSM to IDLE the next cycle.
REQ-034 Reset mid-stream: reset=1 after 3 words -> all outputs return to their reset values, conv_rst=1; the next load completes with the correct key.
